sobel_core: RTL

SOBEL_CORE -- requirements
Module: sobel_core

---
 rtl/sobel_core.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sobel_core.sv
// Three-stage Sobel edge detector on a pre-assembled 3x3 neighbourhood, with a
// per-frame edge counter and a holding register for the previous frame's total.
module sobel_core #(
  parameter int THRESHOLD = 128,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             border,
  input  logic             frame_start,
  input  logic [7:0]       pix_0,
  input  logic [7:0]       pix_1,
  input  logic [7:0]       pix_2,
  input  logic [7:0]       pix_3,
  input  logic [7:0]       pix_5,
  input  logic [7:0]       pix_6,
  input  logic [7:0]       pix_7,
  input  logic [7:0]       pix_8,
  output logic             out_valid,
  output logic [7:0]       edge_mag,
  output logic             edge_bit,
  output logic [CNT_W-1:0] edge_count,
  output logic [CNT_W-1:0] edge_count_last
);

  localparam logic [10:0] THR = 11'(THRESHOLD);

  // Stage 1: weighted column/row sums
  logic       v1_q, b1_q;
  logic [9:0] gxp_q, gxn_q, gyp_q, gyn_q;
  logic [9:0] gxp_d, gxn_d, gyp_d, gyn_d;

  // Stage 2: absolute gradients
  logic       v2_q, b2_q;
  logic [9:0] ax_q, ay_q;
  logic [9:0] ax_d, ay_d;
  logic signed [10:0] dx, dy, dx_neg, dy_neg;

  // Stage 3: magnitude, saturation, threshold
  logic        out_valid_q, edge_bit_q, edge_bit_d;
  logic [7:0]  edge_mag_q, edge_mag_d, mag_sat;
  logic [10:0] mag;

  logic [CNT_W-1:0] count_q, count_d, count_last_q, count_last_d;
  logic             count_inc;

  // NOTE: all combinational logic uses blocking assignments and assigns every
  // output unconditionally, so no latches can be inferred.
  always_comb begin
    gxp_d = {2'b0, pix_2} + {1'b0, pix_5, 1'b0} + {2'b0, pix_8};
    gxn_d = {2'b0, pix_0} + {1'b0, pix_3, 1'b0} + {2'b0, pix_6};
    gyp_d = {2'b0, pix_6} + {1'b0, pix_7, 1'b0} + {2'b0, pix_8};
    gyn_d = {2'b0, pix_0} + {1'b0, pix_1, 1'b0} + {2'b0, pix_2};

    // 11-bit signed difference of two 10-bit unsigned values cannot overflow
    dx     = $signed({1'b0, gxp_q}) - $signed({1'b0, gxn_q});
    dy     = $signed({1'b0, gyp_q}) - $signed({1'b0, gyn_q});
    dx_neg = -dx;
    dy_neg = -dy;
    ax_d   = dx[10] ? dx_neg[9:0] : dx[9:0];
    ay_d   = dy[10] ? dy_neg[9:0] : dy[9:0];

    mag        = {1'b0, ax_q} + {1'b0, ay_q};
    mag_sat    = (mag > 11'd255) ? 8'd255 : mag[7:0];
    edge_mag_d = (v2_q && !b2_q) ? mag_sat : 8'd0;
    edge_bit_d = v2_q && !b2_q && ({3'b0, mag_sat} >= THR);

    // A pixel emerging on the frame_start cycle belongs to the new frame
    count_inc    = out_valid_q && edge_bit_q;
    count_last_d = count_last_q;
    count_d      = count_q;
    if (frame_start) begin
      count_last_d = count_q;
      count_d      = count_inc ? CNT_W'(1) : '0;
    end else if (count_inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the previous stage's value from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q         <= 1'b0;
      b1_q         <= 1'b0;
      gxp_q        <= '0;
      gxn_q        <= '0;
      gyp_q        <= '0;
      gyn_q        <= '0;
      v2_q         <= 1'b0;
      b2_q         <= 1'b0;
      ax_q         <= '0;
      ay_q         <= '0;
      out_valid_q  <= 1'b0;
      edge_mag_q   <= '0;
      edge_bit_q   <= 1'b0;
      count_q      <= '0;
      count_last_q <= '0;
    end else begin
      v1_q         <= in_valid;
      b1_q         <= border;
      gxp_q        <= gxp_d;
      gxn_q        <= gxn_d;
      gyp_q        <= gyp_d;
      gyn_q        <= gyn_d;
      v2_q         <= v1_q;
      b2_q         <= b1_q;
      ax_q         <= ax_d;
      ay_q         <= ay_d;
      out_valid_q  <= v2_q;
      edge_mag_q   <= edge_mag_d;
      edge_bit_q   <= edge_bit_d;
      count_q      <= count_d;
      count_last_q <= count_last_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign edge_mag        = edge_mag_q;
  assign edge_bit        = edge_bit_q;
  assign edge_count      = count_q;
  assign edge_count_last = count_last_q;

endmodule
